// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register chain: skid depth,
// occupancy-width helper and the default-width stage record.
package pipe_pkg;

    localparam int SKID_DEPTH        = 2;
    localparam int PAYLOAD_W_DEFAULT = 32;

    typedef struct packed {
        logic                         valid;
        logic [PAYLOAD_W_DEFAULT-1:0] data;
    } pipe_rec_t;

    // Wide enough for every stage plus a full skid buffer.
    function automatic int occ_w(input int depth);
        return $clog2(depth + SKID_DEPTH + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready bus of the pipeline register chain, with the per-stage flush
// vector and the occupancy readback.
interface pipe_reg_chain_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = occ_w(DEPTH)
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] flush;
    logic             flush_in;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output in_valid, in_data, out_ready, flush, flush_in,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, flush_in,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO skid buffer placed ahead of stage 0 when PIPE_SKID_EN is set.
// o_ready is registered so the upstream ready never sees out_ready combinationally.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_clear,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_ready
);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic [1:0]       w_count_next;
    logic             r_ready;

    always_comb begin
        w_count_next = r_count;
        if (i_clear) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SKID_DEPTH; k++) r_mem[k] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next != 2'(SKID_DEPTH));
            if (i_clear) begin
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (i_push) begin
                    r_mem[r_wr_ptr] <= i_data;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (i_pop) r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_ready = r_ready;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage valid/ready register chain with bubble collapsing and
// per-stage flush. Define PIPE_SKID_EN to add a 2-entry skid with registered in_ready.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = occ_w(DEPTH)
) (
    input logic             clk,
    input logic             rst,
    pipe_reg_chain_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           r_stage [DEPTH];
    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_valid;
    logic [DEPTH-1:0] w_valid_next;
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic             w_head_valid;
    logic [WIDTH-1:0] w_head_data;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign w_v[gi] = r_stage[gi].valid;
            // A stage is ready when it or any stage downstream of it has a hole.
            assign w_rdy[gi] = bus.out_ready | ~(&w_v[DEPTH-1:gi]);
            if (gi == 0) begin : g_head
                assign w_src_valid[gi] = w_head_valid;
                assign w_src_data[gi]  = w_head_data;
            end else begin : g_link
                assign w_src_valid[gi] = w_v[gi-1] & ~bus.flush[gi-1];
                assign w_src_data[gi]  = r_stage[gi-1].data;
            end
            assign w_load[gi]       = w_rdy[gi] & w_src_valid[gi];
            assign w_valid_next[gi] = (w_rdy[gi] ? w_src_valid[gi] : w_v[gi]) & ~bus.flush[gi];
        end
    endgenerate

    always_comb begin
        w_occ_next = '0;
        for (int k = 0; k < DEPTH; k++) w_occ_next = w_occ_next + CNT_W'(w_valid_next[k]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
            r_occ <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k].valid <= w_valid_next[k];
                if (w_load[k]) r_stage[k].data <= w_src_data[k];
            end
            r_occ <= w_occ_next;
        end
    end

`ifdef PIPE_SKID_EN
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic [1:0]       w_skid_count;
    logic             w_skid_ready;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    assign w_accept = bus.in_valid & w_skid_ready;
    // Skid drains first to keep FIFO order; an empty skid is bypassed.
    assign w_head_valid = (w_skid_valid | w_accept) & ~bus.flush_in;
    assign w_head_data  = w_skid_valid ? w_skid_data : bus.in_data;
    assign w_pop        = w_skid_valid & w_rdy[0];
    assign w_push       = w_accept & ~bus.flush_in & (w_skid_valid | ~w_rdy[0]);

    pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.in_data),
        .i_pop   (w_pop),
        .i_clear (bus.flush_in),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_count (w_skid_count),
        .o_ready (w_skid_ready)
    );

    assign bus.in_ready  = w_skid_ready;
    assign bus.occupancy = r_occ + CNT_W'(w_skid_count);
`else
    assign w_head_valid  = bus.in_valid & ~bus.flush_in;
    assign w_head_data   = bus.in_data;
    assign bus.in_ready  = w_rdy[0];
    assign bus.occupancy = r_occ;
`endif

    assign bus.out_valid = r_stage[DEPTH-1].valid;
    assign bus.out_data  = r_stage[DEPTH-1].data;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (DEPTH=3): the driver queues expected
// beats and occupancy deltas, an independent negedge monitor checks outputs.
module tb_pipe_reg_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    int          exp_occ   = 0;
    int          pend_acc  = 0;
    int          pend_kill = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; returns 3 time units after the edge, before the next negedge.
    task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                         input logic [DEPTH-1:0] fl, input logic fin, input int kill);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.flush_in  = fin;
        #2;
        if (v && bus.in_ready && !fin) begin
            exp_q.push_back(d);
            pend_acc = 1;
        end else begin
            pend_acc = 0;
        end
        pend_kill = kill;
        repeat (kill) void'(exp_q.pop_back());
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, ordy, '0, 1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = '0;
        bus.flush_in  = 1'b0;
        pend_acc      = 0;
        pend_kill     = 0;
        repeat (n - 1) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
    endtask

    // Monitor: occupancy and ready against the count model, output beats against the queue.
    always @(negedge clk) begin : monitor
        logic        xfer;
        logic [31:0] e;
        if (!rst) begin
            exp_q.delete();
            exp_occ = 0;
        end else begin
            check("occupancy", 32'(bus.occupancy), 32'(exp_occ));
`ifndef PIPE_SKID_EN
            check("in_ready", 32'(bus.in_ready), 32'((exp_occ < DEPTH) || bus.out_ready));
`endif
            xfer = bus.out_valid && bus.out_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got 0x%0h expected no beat", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e);
                    $display("beat out data=0x%0h expected=0x%0h", bus.out_data, e);
                end
            end
            exp_occ = exp_occ + pend_acc - (xfer ? 1 : 0) - pend_kill;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic v_r;
        logic o_r;
        logic f_r;
        int   occ_before;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = '0;
        bus.flush_in  = 1'b0;

        // Reset state
        do_reset(3);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        idle(1'b1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming 1..8 with out_ready high: first beat after DEPTH-1 more edges
        for (int c = 0; c < 11; c++) begin
            drive(c < 8, 32'(c + 1), 1'b1, '0, 1'b0, 0);
            check("stream_out_valid", 32'(bus.out_valid), 32'(c >= DEPTH));
        end
        repeat (3) idle(1'b1);

        // Fill then stall
        drive(1'b1, 32'hA, 1'b0, '0, 1'b0, 0);
        drive(1'b1, 32'hB, 1'b0, '0, 1'b0, 0);
        drive(1'b1, 32'hC, 1'b0, '0, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            idle(1'b0);
`ifndef PIPE_SKID_EN
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
`endif
            check("full_occupancy", 32'(bus.occupancy), 32'd3);
            check("full_out_data", bus.out_data, 32'hA);
        end
        repeat (5) idle(1'b1);

        // Bubble collapse while output stalled
        drive(1'b1, 32'h11, 1'b0, '0, 1'b0, 0);
        idle(1'b0);
        drive(1'b1, 32'h33, 1'b0, '0, 1'b0, 0);
        idle(1'b0);
        idle(1'b0);
        check("bubble_in_ready", 32'(bus.in_ready), 32'd1);
        check("bubble_occupancy", 32'(bus.occupancy), 32'd2);
        check("bubble_out_data", bus.out_data, 32'h11);
        repeat (4) idle(1'b1);

        // Flush of stages 0-1 while stage 2 transfers out
        drive(1'b1, 32'h1, 1'b0, '0, 1'b0, 0);
        drive(1'b1, 32'h2, 1'b0, '0, 1'b0, 0);
        drive(1'b1, 32'h3, 1'b0, '0, 1'b0, 0);
        idle(1'b0);
`ifndef PIPE_SKID_EN
        check("flush_pre_in_ready", 32'(bus.in_ready), 32'd0);
`endif
        drive(1'b0, 32'h0, 1'b1, 3'b011, 1'b0, 2);
        idle(1'b0);
        check("flush_occupancy", 32'(bus.occupancy), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) idle(1'b1);

        // flush_in drops the upstream beat but still reports ready
        drive(1'b1, 32'h44, 1'b0, '0, 1'b0, 0);
        idle(1'b0);
        occ_before = int'(bus.occupancy);
        drive(1'b1, 32'h55, 1'b0, '0, 1'b1, 0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        idle(1'b0);
        check("flush_in_occupancy", 32'(bus.occupancy), 32'(occ_before));
        repeat (5) idle(1'b1);

        // Reset mid-operation
        drive(1'b1, 32'h66, 1'b0, '0, 1'b0, 0);
        drive(1'b1, 32'h77, 1'b0, '0, 1'b0, 0);
        idle(1'b0);
        check("pre_rst_occupancy", 32'(bus.occupancy), 32'd2);
        do_reset(1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", bus.out_data, 32'd0);
        check("mid_rst_occupancy", 32'(bus.occupancy), 32'd0);
        idle(1'b1);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (5) idle(1'b1);

        // Randomized traffic with alternating backpressure phases
        for (int n = 0; n < 400; n++) begin
            v_r = ($urandom_range(0, 3) != 0);
            o_r = ((n % 80) < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
`ifndef PIPE_SKID_EN
            f_r = ($urandom_range(0, 15) == 0);
`else
            f_r = 1'b0;
`endif
            drive(v_r, $urandom, o_r, '0, f_r, 0);
        end
        repeat (12) idle(1'b1);
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_occupancy", 32'(bus.occupancy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
